// File: rtl/quant_matrix_loader_if.sv
// -----------------------------------------------------------------------------
// quant_matrix_loader_if
// Byte stream carrying quantiser matrix entries from the header parser to the
// matrix loader. The stream is valid/ready. A byte transfers on a rising clock
// edge when in_valid and in_ready are both high.
//
// Signals:
//   in_dta   [DTA_WIDTH-1:0]  matrix byte                (master -> slave)
//   in_valid                  in_dta carries a byte      (master -> slave)
//   in_ready                  slave takes in_dta now     (slave  -> master)
// Modports:
//   master  header parser side (produces bytes)
//   slave   loader side (consumes bytes)
// -----------------------------------------------------------------------------
interface quant_matrix_loader_if #(
    parameter int DTA_WIDTH = 8
);
    logic [DTA_WIDTH-1:0] in_dta;
    logic                 in_valid;
    logic                 in_ready;

    modport master (
        output in_dta,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_dta,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/quant_matrix_loader.sv
// -----------------------------------------------------------------------------
// quant_matrix_loader
// This is the writer side of the intra and non-intra quantiser matrix stores.
// It takes 64 matrix bytes in zigzag transmission order from the byte stream.
// It emits one write strobe per byte. The address of each write is the
// transmission index, and the stores do the inverse scan. It also emits the
// rst_values pulse, which makes both stores restore their default matrices
// when a sequence header is decoded.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous reset, active low
//   seq_hdr          pulse: sequence header decoded (aborts any load)
//   start_intra      pulse: an intra matrix load follows
//   start_non_intra  pulse: a non-intra matrix load follows
//   in_bus           byte stream (slave modport: in_dta, in_valid, in_ready)
//   wr_addr          transmission index of the entry being written
//   wr_dta           entry value
//   intra_wr_en      write strobe, intra store
//   non_intra_wr_en  write strobe, non-intra store
//   wr_clk_en        qualifies the write strobes and rst_values
//   rst_values       restore default matrices in both stores
//   busy             load in progress or pending
//   done             high for the one cycle in which entry 63 is presented
//   error            sticky flag: a zero entry was received (option only)
//
// Build option:
//   QMAT_ZERO_CHECK_EN  When defined, a received 0 is written as 1 and error
//                       is set until the next seq_hdr or reset. When it is
//                       not defined, bytes pass unchanged and error is tied
//                       to 0.
// -----------------------------------------------------------------------------
module quant_matrix_loader #(
    parameter  int MAT_SIZE  = 64,
    parameter  int DTA_WIDTH = 8,
    localparam int ADDR_W    = $clog2(MAT_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seq_hdr,
    input  logic                 start_intra,
    input  logic                 start_non_intra,
    quant_matrix_loader_if.slave in_bus,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DTA_WIDTH-1:0] wr_dta,
    output logic                 intra_wr_en,
    output logic                 non_intra_wr_en,
    output logic                 wr_clk_en,
    output logic                 rst_values,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD_I  = 2'd1;
    localparam logic [1:0] ST_LOAD_NI = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAT_SIZE - 1);

    logic [1:0]           state_reg, state_next;
    logic [ADDR_W-1:0]    cnt_reg, cnt_next;
    logic                 pend_ni_reg, pend_ni_next;
    logic                 in_ready_reg;
    logic [ADDR_W-1:0]    wr_addr_reg;
    logic [DTA_WIDTH-1:0] wr_dta_reg;
    logic                 intra_wr_en_reg, non_intra_wr_en_reg;
    logic                 wr_clk_en_reg, rst_values_reg;
    logic                 busy_reg, done_reg;

    logic                 accept;
    logic [DTA_WIDTH-1:0] dta_fixed;
    logic                 zero_seen;

    // A seq_hdr cycle never takes a byte. The registered ready is masked by
    // seq_hdr in that cycle, so the parser does not see a false handshake for
    // the byte it presents while the header aborts the load.
    assign in_bus.in_ready = in_ready_reg & ~seq_hdr;
    assign accept          = in_bus.in_valid & in_ready_reg & ~seq_hdr;
    assign zero_seen       = accept && (in_bus.in_dta == '0);

`ifdef QMAT_ZERO_CHECK_EN
    logic error_reg;

    // 0 is a forbidden quantiser value, so the nearest legal value (1) is
    // stored in its place.
    assign dta_fixed = (in_bus.in_dta == '0) ? DTA_WIDTH'(1) : in_bus.in_dta;
    assign error     = error_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            error_reg <= 1'b0;
        end else if (seq_hdr) begin
            error_reg <= 1'b0;
        end else if (zero_seen) begin
            error_reg <= 1'b1;
        end
    end
`else
    logic unused_zero;

    assign dta_fixed   = in_bus.in_dta;
    assign error       = 1'b0;
    assign unused_zero = zero_seen;
`endif

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pend_ni_next = pend_ni_reg;
        if (seq_hdr) begin
            // The header aborts everything. Any start pulse in this cycle is dropped.
            state_next   = ST_IDLE;
            cnt_next     = '0;
            pend_ni_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_intra) begin
                        // When both loads start together, intra goes first
                        // and non-intra is queued.
                        state_next   = ST_LOAD_I;
                        pend_ni_next = start_non_intra;
                    end else if (start_non_intra) begin
                        state_next = ST_LOAD_NI;
                    end
                end
                ST_LOAD_I, ST_LOAD_NI: begin
                    if (state_reg == ST_LOAD_I && start_non_intra) begin
                        pend_ni_next = 1'b1;
                    end
                    if (accept) begin
                        if (cnt_reg == LAST_IDX) begin
                            cnt_next   = '0;
                            state_next = ST_DONE;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    if (pend_ni_reg) begin
                        pend_ni_next = 1'b0;
                        state_next   = ST_LOAD_NI;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg           <= ST_IDLE;
            cnt_reg             <= '0;
            pend_ni_reg         <= 1'b0;
            in_ready_reg        <= 1'b0;
            wr_addr_reg         <= '0;
            wr_dta_reg          <= '0;
            intra_wr_en_reg     <= 1'b0;
            non_intra_wr_en_reg <= 1'b0;
            wr_clk_en_reg       <= 1'b0;
            rst_values_reg      <= 1'b0;
            busy_reg            <= 1'b0;
            done_reg            <= 1'b0;
        end else begin
            state_reg           <= state_next;
            cnt_reg             <= cnt_next;
            pend_ni_reg         <= pend_ni_next;
            in_ready_reg        <= (state_next == ST_LOAD_I) || (state_next == ST_LOAD_NI);
            intra_wr_en_reg     <= accept && (state_reg == ST_LOAD_I);
            non_intra_wr_en_reg <= accept && (state_reg == ST_LOAD_NI);
            // accept already excludes seq_hdr, so a write and rst_values
            // can never be high in the same cycle.
            wr_clk_en_reg       <= accept | seq_hdr;
            rst_values_reg      <= seq_hdr;
            busy_reg            <= (state_next != ST_IDLE) || pend_ni_next;
            done_reg            <= (state_next == ST_DONE);
            if (accept) begin
                wr_addr_reg <= cnt_reg;
                wr_dta_reg  <= dta_fixed;
            end
        end
    end

    assign wr_addr         = wr_addr_reg;
    assign wr_dta          = wr_dta_reg;
    assign intra_wr_en     = intra_wr_en_reg;
    assign non_intra_wr_en = non_intra_wr_en_reg;
    assign wr_clk_en       = wr_clk_en_reg;
    assign rst_values      = rst_values_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;

endmodule

// File: tb/tb_quant_matrix_loader.sv
// -----------------------------------------------------------------------------
// tb_quant_matrix_loader
// Directed bench for quant_matrix_loader. Each accepted byte is checked one
// cycle later against the expected address, data and strobe. A negedge
// monitor counts strobes and done pulses so the totals can be compared at the
// end of each scenario. Build with +define+QMAT_ZERO_CHECK_EN to exercise the
// zero-entry option.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_quant_matrix_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       seq_hdr = 1'b0;
    logic       start_intra = 1'b0;
    logic       start_non_intra = 1'b0;
    logic [5:0] wr_addr;
    logic [7:0] wr_dta;
    logic       intra_wr_en, non_intra_wr_en, wr_clk_en;
    logic       rst_values, busy, done, error;

    quant_matrix_loader_if #(.DTA_WIDTH(8)) bus ();

    quant_matrix_loader #(.MAT_SIZE(64), .DTA_WIDTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .seq_hdr         (seq_hdr),
        .start_intra     (start_intra),
        .start_non_intra (start_non_intra),
        .in_bus          (bus.slave),
        .wr_addr         (wr_addr),
        .wr_dta          (wr_dta),
        .intra_wr_en     (intra_wr_en),
        .non_intra_wr_en (non_intra_wr_en),
        .wr_clk_en       (wr_clk_en),
        .rst_values      (rst_values),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    always #5 clk = ~clk;

`ifdef QMAT_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    // Default intra matrix values, used here only as a varied byte pattern.
    logic [7:0] intra_tbl [64] = '{
        8, 16, 19, 22, 26, 27, 29, 34,  16, 16, 22, 24, 27, 29, 34, 37,
        19, 22, 26, 27, 29, 34, 34, 38, 22, 22, 26, 27, 29, 34, 37, 40,
        22, 26, 27, 29, 32, 35, 40, 48, 26, 27, 29, 32, 35, 40, 48, 58,
        26, 27, 29, 34, 38, 46, 56, 69, 27, 29, 35, 38, 46, 56, 69, 83};

    int n_checks = 0;
    int n_fail   = 0;
    int intra_cnt = 0, ni_cnt = 0, done_cnt = 0, clash_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (intra_wr_en)     intra_cnt++;
            if (non_intra_wr_en) ni_cnt++;
            if (done)            done_cnt++;
            if (rst_values && (intra_wr_en || non_intra_wr_en)) clash_cnt++;
        end
    end

    task automatic clear_counts();
        intra_cnt = 0; ni_cnt = 0; done_cnt = 0; clash_cnt = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte, wait for it to be taken (bounded), then check the write one cycle later.
    task automatic push(input logic [7:0] b, input bit intra, input logic [5:0] addr);
        logic [7:0]  exp_d;
        logic [16:0] exp_w;
        bus.in_dta   = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready) break;
            step();
        end
        check_val("ready_wait", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        exp_d = (ZC && b == 8'd0) ? 8'd1 : b;
        exp_w = {intra, ~intra, 1'b1, addr, exp_d};
        check_val("write", {15'd0, intra_wr_en, non_intra_wr_en, wr_clk_en, wr_addr, wr_dta}, {15'd0, exp_w});
        $display("write %s addr=%0d dta=%0d", intra ? "intra" : "non_intra", wr_addr, wr_dta);
    endtask

    task automatic pulse(input bit s_i, input bit s_ni, input bit s_hdr);
        start_intra     = s_i;
        start_non_intra = s_ni;
        seq_hdr         = s_hdr;
        step();
        start_intra     = 1'b0;
        start_non_intra = 1'b0;
        seq_hdr         = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return {6'd0, bus.in_ready, wr_addr, wr_dta, intra_wr_en, non_intra_wr_en,
                wr_clk_en, rst_values, busy, done, error};
    endfunction

    initial begin
        bus.in_dta   = 8'd0;
        bus.in_valid = 1'b0;
        #12;
        check_val("reset_outs", all_outs(), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Reset in the middle of an intra load, at cnt = 20.
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) push(intra_tbl[i], 1'b1, 6'(i));
        rst = 1'b0;
        #1;
        check_val("async_reset_outs", all_outs(), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Full intra load with in_valid toggling every other cycle.
        clear_counts();
        pulse(1'b1, 1'b0, 1'b0);
        check_val("busy_load", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 64; i++) begin
            push(intra_tbl[i], 1'b1, 6'(i));
            if (i == 63) begin
                check_val("done_pulse", {31'd0, done}, 32'd1);
                check_val("ready_after_last", {31'd0, bus.in_ready}, 32'd0);
            end
            step();
            check_val("gap_no_write", {29'd0, intra_wr_en, non_intra_wr_en, wr_clk_en}, 32'd0);
        end
        check_val("idle_busy_done", {30'd0, busy, done}, 32'd0);
        check_val("intra_count", intra_cnt, 32'd64);
        check_val("ni_count_zero", ni_cnt, 32'd0);
        check_val("done_count", done_cnt, 32'd1);

        // Both starts together: intra load, then the queued non-intra load.
        clear_counts();
        pulse(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) push(8'd16, 1'b1, 6'(i));
        check_val("dual_done1", {30'd0, done, busy}, 32'd3);
        for (int i = 0; i < 64; i++) push(8'd16, 1'b0, 6'(i));
        check_val("dual_done2", {31'd0, done}, 32'd1);
        step();
        check_val("dual_busy_low", {30'd0, busy, bus.in_ready}, 32'd0);
        check_val("dual_intra_cnt", intra_cnt, 32'd64);
        check_val("dual_ni_cnt", ni_cnt, 32'd64);
        check_val("dual_done_cnt", done_cnt, 32'd2);

        // seq_hdr aborts a non-intra load at cnt = 30.
        clear_counts();
        pulse(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) push(8'(i + 1), 1'b0, 6'(i));
        seq_hdr      = 1'b1;
        bus.in_dta   = 8'hAA;
        bus.in_valid = 1'b1;
        #1;
        check_val("hdr_ready_forced", {31'd0, bus.in_ready}, 32'd0);
        step();
        seq_hdr = 1'b0;
        check_val("hdr_pulse",
                  {26'd0, rst_values, wr_clk_en, intra_wr_en, non_intra_wr_en, bus.in_ready, busy},
                  32'b110000);
        step();
        check_val("hdr_after",
                  {26'd0, rst_values, wr_clk_en, intra_wr_en, non_intra_wr_en, bus.in_ready, busy},
                  32'd0);
        bus.in_valid = 1'b0;
        check_val("hdr_ni_cnt", ni_cnt, 32'd30);
        pulse(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) push(8'(i + 100), 1'b0, 6'(i));
        check_val("restart_done", {31'd0, done}, 32'd1);
        step();

        // seq_hdr together with start_intra: only the rst_values pulse.
        bus.in_dta   = 8'h55;
        bus.in_valid = 1'b1;
        pulse(1'b1, 1'b0, 1'b1);
        check_val("hdr_start_pulse",
                  {26'd0, rst_values, wr_clk_en, intra_wr_en, non_intra_wr_en, bus.in_ready, busy},
                  32'b110000);
        step();
        check_val("hdr_start_idle",
                  {26'd0, rst_values, wr_clk_en, intra_wr_en, non_intra_wr_en, bus.in_ready, busy},
                  32'd0);
        bus.in_valid = 1'b0;

        // A zero byte at index 5.
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            push((i == 5) ? 8'd0 : 8'(i + 40), 1'b1, 6'(i));
            if (i == 5) check_val("zero_error_set", {31'd0, error}, {31'd0, ZC});
        end
        step();
        check_val("zero_error_sticky", {31'd0, error}, {31'd0, ZC});
        pulse(1'b0, 1'b0, 1'b1);
        check_val("zero_error_clear", {31'd0, error}, 32'd0);
        check_val("no_clash", clash_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/quant_matrix_loader.md
Name: quant_matrix_loader

Overview:
- Writer side of the intra/non-intra quantiser matrix stores.
- Takes the 64 matrix bytes, in zigzag transmission order, from the header parser through a valid/ready byte stream.
- Generates the write strobes those stores consume: wr_addr = transmission index 0..63, data, wr_en, wr_clk_en.
- Also generates the rst_values pulse that restores default matrices when a sequence header is decoded. Inverse scan is done in the stores, not here.

Parameters:
- MAT_SIZE, 64, entries per matrix; wr_addr width is log2(MAT_SIZE) = 6.
- DTA_WIDTH, 8, bits per matrix entry.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active low.
- seq_hdr  input  1  one-cycle pulse: sequence_header_code decoded.
- start_intra  input  1  one-cycle pulse: load_intra_quantiser_matrix = 1; 64 bytes follow.
- start_non_intra  input  1  one-cycle pulse: load_non_intra_quantiser_matrix = 1; 64 bytes follow.
- in_dta  input  8  matrix byte.
- in_valid  input  1  in_dta valid.
- in_ready  output  1  loader accepts in_dta this cycle.
- wr_addr  output  6  transmission (zigzag) index of the entry being written.
- wr_dta  output  8  entry value.
- intra_wr_en  output  1  write strobe to intra matrix store.
- non_intra_wr_en  output  1  write strobe to non-intra matrix store.
- wr_clk_en  output  1  qualifies the write and rst_values outputs for the stores.
- rst_values  output  1  restore default matrices (both stores).
- busy  output  1  load in progress or pending.
- done  output  1  one-cycle pulse after entry 63 of a matrix is written.
- error  output  1  sticky zero-entry flag (see Optional Feature).

Behaviour:
- Reset (rst low, asynchronous) drives every output to 0: in_ready, wr_addr, wr_dta, intra_wr_en, non_intra_wr_en, wr_clk_en, rst_values, busy, done, error. State = IDLE, cnt = 0, pend_ni = 0.
- All outputs are registered.
- States:
  - IDLE: in_ready = 0.
    - start_intra -> LOAD_I.
    - start_non_intra alone -> LOAD_NI.
    - Both pulses in the same cycle -> LOAD_I and set pend_ni.
  - LOAD_I / LOAD_NI: in_ready = 1. Each cycle with in_valid & in_ready:
    - next cycle wr_addr = cnt, wr_dta = in_dta, the matching *_wr_en = 1, wr_clk_en = 1;
    - cnt increments.
    - Latency is one cycle from accept to write.
    - No write strobes on cycles without a transfer.
  - On the accept with cnt == 63: cnt wraps to 0, state -> DONE. in_ready is 0 from the following cycle.
  - DONE (one cycle): done = 1.
    - If pend_ni: clear pend_ni, go to LOAD_NI.
    - Otherwise go to IDLE.
- Start pulses:
  - start_non_intra during LOAD_I sets pend_ni.
  - Any other start pulse while not IDLE is ignored.
- busy = (state != IDLE) | pend_ni.
- Sequence header:
  - seq_hdr in any state: next cycle rst_values = 1 and wr_clk_en = 1 for one cycle, with no *_wr_en.
  - It aborts any load in progress: cnt = 0, pend_ni = 0, state = IDLE. The byte presented that cycle is not accepted (in_ready forced 0 that cycle).
  - seq_hdr has priority over start_* in the same cycle; the start pulse is dropped.
  - error clears on seq_hdr.
- wr_clk_en = write strobe OR rst_values. Writes and rst_values never coincide.

Optional Feature:
- Macro QMAT_ZERO_CHECK_EN.
- Defined:
  - An accepted byte of 0 (a forbidden quantiser value) is written as 8'd1.
  - error sets and stays set until seq_hdr or reset.
- Undefined:
  - Bytes pass through unchanged.
  - error is constant 0.

Test Plan:
- Reset mid-LOAD_I at cnt = 20 -> all outputs 0 immediately. After release, a start_intra plus 64 bytes writes addresses 0..63 from 0.
- start_intra, then bytes 8,16,19,... with in_valid toggling every other cycle -> exactly 64 intra_wr_en pulses, wr_addr 0..63 in order, each one cycle after its accept. done pulses once. non_intra_wr_en never asserts.
- start_intra and start_non_intra in the same cycle, then 128 bytes of value 16 -> 64 intra writes, one done, 64 non-intra writes with wr_addr restarting at 0, second done, busy low afterwards.
- seq_hdr at cnt = 30 of LOAD_NI -> rst_values and wr_clk_en high one cycle, no further writes, in_ready 0, IDLE. A following start_non_intra restarts at wr_addr 0.
- seq_hdr and start_intra in the same cycle -> rst_values pulse only. The loader stays IDLE and in_ready stays 0.
- QMAT_ZERO_CHECK_EN defined, byte 0 at index 5 -> wr_dta = 1 at wr_addr 5, error = 1 until the next seq_hdr. Macro undefined -> wr_dta = 0, error stays 0.
